sha3_output_interface: RTL and testbench
========================================

Name: sha3_output_interface

Overview:
- Transmit side of the 200-bit chunked state interface used by the SHA-3 datapath.
- Captures a finished 1600-bit Keccak state (5x5 lanes of 64 bits) in one cycle when the permutation core asserts load.
- Emits the state as consecutive 200-bit chunks tagged with chunk index dox, under a pushout/stopout handshake.
- Chunk/lane packing is the exact inverse of the input-side loader, so a loopback of the two interfaces reproduces the state bit-exactly.

Parameters:
- NOUT, 8, number of chunks emitted per state, legal 1..8 (8 = full state; 2 = SHA3-256 digest plus surplus bits).
- CHUNK_W, 200, chunk width in bits; fixed by the interface, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  state_in valid; accepted only when ready=1.
- state_in  input  1600  flattened state; lane (x,y) occupies bits 64*(x+5y)+63 : 64*(x+5y).
- ready  output  1  block idle and able to accept load.
- pushout  output  1  dout/dox valid.
- stopout  input  1  receiver back-pressure; a transfer occurs on a clk edge where pushout=1 and stopout=0.
- dox  output  3  index of the chunk currently presented.
- dout  output  200  chunk data; chunk k = state bits 200k+199 : 200k.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ready=1, pushout=0, dox=0, dout=0, capture register cleared. All outputs are registered.
- Chunk k (x+5y linear lane order, same as the loader):
  - k=0: lanes (0,0),(1,0),(2,0), then (3,0)[7:0] in dout[199:192].
  - k=1: (3,0)[63:8], (4,0), (0,1), (1,1)[15:0], continuing the same way through k=7.
- FSM states:
  - IDLE: ready=1, pushout=0. load=1 -> capture state_in, cnt=0, go to SEND. On the next edge pushout=1, dox=0, dout=chunk0 (first valid data one cycle after load).
  - SEND: ready=0, pushout=1.
    - Transfer with cnt<NOUT-1: cnt+1; dox and dout update to the next chunk on the same edge, allowing one chunk per cycle with stopout held low.
    - Transfer with cnt=NOUT-1: go to IDLE; pushout=0 and ready=1 from that edge.
- Stall: while pushout=1 and stopout=1, dox, dout and pushout hold unchanged for any number of cycles.
- load while ready=0: ignored; the captured state is not disturbed.
- Minimum spacing between accepted loads: NOUT+1 cycles (one idle cycle after the last transfer).
- stopout while pushout=0: don't-care.
- dox wrap: counter is 3 bits. It never exceeds NOUT-1 and always restarts at 0 for a new state.
- Reset asserted mid-SEND: immediate return to IDLE with the reset values above; the partial transfer is abandoned and no further chunks are emitted.
- dout is 0 whenever pushout=0.

Optional Feature:
- OUTPUT_PARITY_EN defined:
  - Adds output dpar (1 bit), registered alongside dout, equal to XOR-reduce of dout (even parity over the 200 bits).
  - dpar resets to 0 and holds during stalls.
- OUTPUT_PARITY_EN undefined: no dpar port; behaviour otherwise identical.

Test Plan:
- Reset then full drain: load state_in with lane (x,y)=64'h0101010101010101*(x+5y), stopout=0 -> pushout high cycles 1..8 after load; dox=0..7; chunk0 dout[63:0]=0, dout[127:64]=64'h0101..01, dout[199:192]=8'h03; ready=1 on cycle 9.
- Back-pressure: stopout=1 for 5 cycles while dox=3 -> dox=3 and dout constant for those 5 cycles; dox=4 appears one edge after stopout falls.
- Loopback: random state_in (100 seeds) fed through the input-side loader -> reassembled 1600 bits equal state_in exactly.
- Ignored load: second load with a different state at dox=2 -> chunks 2..7 still come from the first state.
- Reset mid-transfer: reset=0 asynchronously at dox=5 -> pushout=0, dout=0, ready=1 with no clock edge; next load starts at dox=0.
- NOUT=2 build, with OUTPUT_PARITY_EN on and off: exactly 2 transfers, then ready=1; with the macro, dpar equals XOR of dout on every valid cycle, including an all-ones chunk (dpar=0).

Source files
------------

// File: rtl/sha3_output_interface.sv
// sha3_output_interface: captures a 1600-bit Keccak state and streams it as NOUT dox-tagged 200-bit chunks.
// First chunk is valid one cycle after load; stopout holds all outputs. Define OUTPUT_PARITY_EN for dpar.
module sha3_output_interface #(
  parameter int NOUT    = 8,
  parameter int CHUNK_W = 200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [1599:0]      state_in,
  output logic               ready,
  output logic               pushout,
  input  logic               stopout,
  output logic [2:0]         dox,
  output logic [CHUNK_W-1:0] dout
`ifdef OUTPUT_PARITY_EN
  ,
  output logic               dpar
`endif
);

  localparam int         NCHUNK   = 8;
  localparam int         STATE_W  = NCHUNK * CHUNK_W;
  localparam logic [2:0] LAST_IDX = 3'(NOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [STATE_W-1:0]   r_cap;
  logic [2:0]           r_cnt;
  logic [2:0]           w_cnt_nxt;
  logic [2:0]           w_cnt_inc;
  logic                 r_ready;
  logic                 w_ready_nxt;
  logic                 r_pushout;
  logic                 w_pushout_nxt;
  logic [CHUNK_W-1:0]   r_dout;
  logic [CHUNK_W-1:0]   w_dout_nxt;
  logic                 w_capture;
  logic [CHUNK_W-1:0]   w_cap_chunks [NCHUNK];

  // Chunk k is simply the k-th 200-bit slice of the x+5y lane-ordered state.
  for (genvar k = 0; k < NCHUNK; k++) begin : g_chunk
    assign w_cap_chunks[k] = r_cap[k*CHUNK_W +: CHUNK_W];
  end

  assign w_cnt_inc = r_cnt + 3'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ready   <= 1'b1;
      r_pushout <= 1'b0;
      r_dout    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ready   <= w_ready_nxt;
      r_pushout <= w_pushout_nxt;
      r_dout    <= w_dout_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cap <= '0;
    end else if (w_capture) begin
      r_cap <= state_in;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_ready_nxt   = r_ready;
    w_pushout_nxt = r_pushout;
    w_dout_nxt    = r_dout;
    w_capture     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          // Chunk 0 comes straight from state_in since the capture lands on the same edge.
          w_capture     = 1'b1;
          w_state_nxt   = S_SEND;
          w_cnt_nxt     = '0;
          w_ready_nxt   = 1'b0;
          w_pushout_nxt = 1'b1;
          w_dout_nxt    = state_in[CHUNK_W-1:0];
        end
      end
      S_SEND: begin
        if (!stopout) begin
          if (r_cnt == LAST_IDX) begin
            w_state_nxt   = S_IDLE;
            w_cnt_nxt     = '0;
            w_ready_nxt   = 1'b1;
            w_pushout_nxt = 1'b0;
            w_dout_nxt    = '0;
          end else begin
            w_cnt_nxt  = w_cnt_inc;
            w_dout_nxt = w_cap_chunks[w_cnt_inc];
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef OUTPUT_PARITY_EN
  logic r_dpar;

  // Parity is computed from the next chunk so it stays aligned with r_dout, stalls included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dpar <= 1'b0;
    end else begin
      r_dpar <= ^w_dout_nxt;
    end
  end

  assign dpar = r_dpar;
`endif

  assign ready   = r_ready;
  assign pushout = r_pushout;
  assign dox     = r_cnt;
  assign dout    = r_dout;

endmodule

// File: tb/tb_sha3_output_interface.sv
// Bench for sha3_output_interface: chunk-level reference model plus directed scenarios on NOUT=8 and NOUT=2 instances.
`timescale 1ns/1ps
module tb_sha3_output_interface;

  localparam int NOUT  = 8;
  localparam int NOUT2 = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          load = 1'b0;
  logic          stopout = 1'b0;
  logic [1599:0] state_in = '0;
  logic          ready;
  logic          pushout;
  logic [2:0]    dox;
  logic [199:0]  dout;

  logic          load2 = 1'b0;
  logic          stopout2 = 1'b0;
  logic [1599:0] state_in2 = '0;
  logic          ready2;
  logic          pushout2;
  logic [2:0]    dox2;
  logic [199:0]  dout2;
`ifdef OUTPUT_PARITY_EN
  logic          dpar;
  logic          dpar2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sha3_output_interface #(.NOUT(NOUT)) u_dut (
    .clk(clk), .reset(rst_n), .load(load), .state_in(state_in), .ready(ready),
    .pushout(pushout), .stopout(stopout), .dox(dox), .dout(dout)
`ifdef OUTPUT_PARITY_EN
    , .dpar(dpar)
`endif
  );

  sha3_output_interface #(.NOUT(NOUT2)) u_dut2 (
    .clk(clk), .reset(rst_n), .load(load2), .state_in(state_in2), .ready(ready2),
    .pushout(pushout2), .stopout(stopout2), .dox(dox2), .dout(dout2)
`ifdef OUTPUT_PARITY_EN
    , .dpar(dpar2)
`endif
  );

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Bit j of chunk k is global bit 200k+j, i.e. bit (g mod 64) of linear lane g/64.
  function automatic logic [199:0] chunk_of(input logic [1599:0] st, input int k);
    logic [199:0] c;
    logic [63:0]  lane;
    int           g;
    for (int j = 0; j < 200; j++) begin
      g    = 200 * k + j;
      lane = st[64 * (g / 64) +: 64];
      c[j] = lane[g % 64];
    end
    return c;
  endfunction

  function automatic logic [1599:0] pattern_state();
    logic [1599:0] s;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        s[64 * (x + 5 * y) +: 64] = 64'h0101010101010101 * 64'(x + 5 * y);
    return s;
  endfunction

  function automatic logic [1599:0] rand_state();
    logic [1599:0] s;
    for (int l = 0; l < 25; l++) s[64 * l +: 64] = {$urandom, $urandom};
    return s;
  endfunction

  // Reference model: a busy flag, the index of the presented chunk and the chunk list.
  logic [199:0] m_chunks [NOUT];
  bit           m_busy = 1'b0;
  int           m_idx  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_idx  = 0;
    end else if (!m_busy) begin
      if (load) begin
        m_busy = 1'b1;
        m_idx  = 0;
        for (int k = 0; k < NOUT; k++) m_chunks[k] = chunk_of(state_in, k);
      end
    end else if (!stopout) begin
      if (m_idx == NOUT - 1) m_busy = 1'b0;
      else m_idx++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chkb("rst_ready", ready, 1'b1);
      chkb("rst_pushout", pushout, 1'b0);
      chki("rst_dox", int'(dox), 0);
      chk("rst_dout", dout, '0);
`ifdef OUTPUT_PARITY_EN
      chkb("rst_dpar", dpar, 1'b0);
`endif
    end else begin
      chkb("ready", ready, !m_busy);
      chkb("pushout", pushout, m_busy);
      chk("dout", dout, m_busy ? m_chunks[m_idx] : 200'd0);
      if (m_busy) chki("dox", int'(dox), m_idx);
`ifdef OUTPUT_PARITY_EN
      if (m_busy) chkb("dpar", dpar, ^m_chunks[m_idx]);
      if (pushout2) chkb("dpar2", dpar2, ^dout2);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dox(input int k);
    int n = 0;
    while (!(pushout && int'(dox) == k) && n < 20) begin
      tick();
      n++;
    end
    chkb("wait_dox", pushout && int'(dox) == k, 1'b1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    chkb("wait_ready", ready, 1'b1);
  endtask

  logic [1599:0] st;
  logic [1599:0] st_b;
  logic [1599:0] asm_st;
  logic [199:0]  saved;
  int            n;
  int            nx;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Full drain of the lane-index pattern with hand-computed chunk fields.
    st = pattern_state();
    state_in = st;
    stopout = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("c0_lane0", 200'(dout[63:0]), 200'd0);
    chk("c0_lane1", 200'(dout[127:64]), 200'(64'h0101010101010101));
    chk("c0_lane3lo", 200'(dout[199:192]), 200'(8'h03));
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) tick();
      if (c == 2) begin
        chk("c1_lane3hi", 200'(dout[55:0]), 200'(56'h03030303030303));
        chk("c1_lane4", 200'(dout[119:56]), 200'(64'h0404040404040404));
        chk("c1_lane6lo", 200'(dout[199:184]), 200'(16'h0606));
      end
      if (c <= 8) begin
        chkb("drain_push", pushout, 1'b1);
        chki("drain_dox", int'(dox), c - 1);
        chkb("drain_busy", ready, 1'b0);
      end else begin
        chkb("drain_ready9", ready, 1'b1);
        chkb("drain_push9", pushout, 1'b0);
      end
    end

    // Back-pressure for five cycles at dox=3.
    st = rand_state();
    state_in = st;
    load = 1'b1;
    tick();
    load = 1'b0;
    wait_dox(3);
    saved = dout;
    stopout = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chki("stall_dox", int'(dox), 3);
      chk("stall_dout", dout, saved);
    end
    chk("stall_chunk3", saved, chunk_of(st, 3));
    stopout = 1'b0;
    tick();
    chki("stall_release_dox", int'(dox), 4);
    wait_ready();

    // Load while busy must not disturb the captured state.
    st = rand_state();
    state_in = st;
    load = 1'b1;
    tick();
    load = 1'b0;
    wait_dox(2);
    st_b = ~st;
    state_in = st_b;
    load = 1'b1;
    tick();
    load = 1'b0;
    wait_dox(5);
    chk("ignored_load_c5", dout, chunk_of(st, 5));
    wait_ready();

    // Asynchronous reset in the middle of a transfer.
    st = rand_state();
    state_in = st;
    load = 1'b1;
    tick();
    load = 1'b0;
    wait_dox(5);
    #1 rst_n = 1'b0;
    #1;
    chkb("arst_pushout", pushout, 1'b0);
    chk("arst_dout", dout, '0);
    chkb("arst_ready", ready, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    st = rand_state();
    state_in = st;
    load = 1'b1;
    tick();
    load = 1'b0;
    chki("post_rst_dox", int'(dox), 0);
    chk("post_rst_c0", dout, chunk_of(st, 0));
    wait_ready();

    // Loopback: reassemble transferred chunks by dox and compare against the loaded state.
    for (int s = 0; s < 100; s++) begin
      st = rand_state();
      state_in = st;
      load = 1'b1;
      tick();
      load = 1'b0;
      asm_st = '0;
      nx = 0;
      n = 0;
      while (!ready && n < 60) begin
        stopout = ($urandom_range(0, 3) == 0);
        if (pushout && !stopout) begin
          asm_st[200 * int'(dox) +: 200] = dout;
          nx++;
        end
        tick();
        n++;
      end
      chkb("loopback_state", asm_st === st, 1'b1);
      chki("loopback_xfers", nx, NOUT);
    end
    stopout = 1'b0;
    tick();

    // NOUT=2 instance: all-ones state, then the pattern state.
    for (int r = 0; r < 2; r++) begin
      st = (r == 0) ? {1600{1'b1}} : pattern_state();
      state_in2 = st;
      load2 = 1'b1;
      tick();
      load2 = 1'b0;
      nx = 0;
      n = 0;
      while (!ready2 && n < 20) begin
        stopout2 = (n == 1);
        if (pushout2 && !stopout2) begin
          chki("n2_dox", int'(dox2), nx);
          if (r == 0) begin
            chk("n2_ones", dout2, {200{1'b1}});
`ifdef OUTPUT_PARITY_EN
            chkb("n2_ones_dpar", dpar2, 1'b0);
`endif
          end else if (nx == 1) begin
            chk("n2_c1_lane3hi", 200'(dout2[55:0]), 200'(56'h03030303030303));
          end
          nx++;
        end
        tick();
        n++;
      end
      chki("n2_xfers", nx, NOUT2);
      chkb("n2_ready", ready2, 1'b1);
      chkb("n2_push_low", pushout2, 1'b0);
      stopout2 = 1'b0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
